// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops words into a 2-entry head/skid buffer and presents them as a valid/ready stream.
// Optional beat counter (beat_cnt, cnt_clr) is compiled in when DRAIN_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
`ifdef DRAIN_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] head_reg, head_next;
  logic [DATA_WIDTH-1:0] skid_reg, skid_next;
  logic                  run_reg;
  logic                  pop;
  logic                  take;

  // run_reg keeps fifo_rd low while reset is held and on the cycle it is released.
  assign pop       = run_reg & en & ~flush & ~fifo_empty & (state_reg != TWO);
  assign fifo_rd   = pop;
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = head_reg;
  assign busy      = (state_reg != EMPTY);
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
      run_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (pop) begin
            state_next = ONE;
            head_next  = fifo_rdata;
          end
        end
        ONE: begin
          if (pop && !take) begin
            state_next = TWO;
            skid_next  = fifo_rdata;
          end else if (pop && take) begin
            head_next  = fifo_rdata;
          end else if (take) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // Skid always holds the younger word, so it moves up on a take.
          if (take) begin
            state_next = ONE;
            head_next  = skid_reg;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

`ifdef DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] beat_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_reg <= '0;
    end else if (cnt_clr) begin
      beat_cnt_reg <= '0;
    end else if (take && !flush) begin
      beat_cnt_reg <= beat_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign beat_cnt = beat_cnt_reg;
`endif

endmodule
